// File: rtl/mat_mul_pkg.sv
// mat_mul_pkg: shared sizes, derived widths and types for the Ising energy engine
package mat_mul_pkg;
  localparam int MEM_BANDWIDTH = 4096;
  localparam int VECTOR_SIZE = 256;
  localparam int J_ELEMENT_WIDTH = 4;
  localparam int J_COLS_PER_READ = MEM_BANDWIDTH / (VECTOR_SIZE * J_ELEMENT_WIDTH);
  localparam int NUM_J_CHUNKS = VECTOR_SIZE / J_COLS_PER_READ;
  localparam int INT_RESULT_WIDTH = $clog2(VECTOR_SIZE) + J_ELEMENT_WIDTH + 1;
  localparam int ENERGY_WIDTH = J_ELEMENT_WIDTH + 2 * $clog2(VECTOR_SIZE) + 1;
  localparam int CNT_W = $clog2(NUM_J_CHUNKS);
  localparam int COL_W = $clog2(J_COLS_PER_READ);
  typedef logic signed [INT_RESULT_WIDTH-1:0] dot_t;
  typedef logic signed [ENERGY_WIDTH-1:0] energy_t;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/mat_mul_energy_signed_col_dot.sv
// signed_col_dot: one column's spin-weighted sum, adding J where s=+1 and subtracting where s=-1
module signed_col_dot
  import mat_mul_pkg::*;
(
  input  logic [VECTOR_SIZE-1:0]                      sigma,
  input  logic [VECTOR_SIZE-1:0][J_ELEMENT_WIDTH-1:0] col,
  output logic signed [INT_RESULT_WIDTH-1:0]          dot
);
  dot_t sum;
  always_comb begin
    sum = '0;
    for (int r = 0; r < VECTOR_SIZE; r++) begin
      sum = sigma[r] ? sum + dot_t'({{(INT_RESULT_WIDTH-J_ELEMENT_WIDTH){1'b0}}, col[r]})
                     : sum - dot_t'({{(INT_RESULT_WIDTH-J_ELEMENT_WIDTH){1'b0}}, col[r]});
    end
  end
  assign dot = sum;
endmodule

// File: rtl/mat_mul_energy.sv
// mat_mul_energy: streams J column chunks and accumulates E = s^T J s, with optional early abort
module mat_mul_energy
  import mat_mul_pkg::*;
(
  input  logic                                                             clk,
  input  logic                                                             rst_n,
  input  logic                                                             start,
  input  logic [VECTOR_SIZE-1:0]                                           sigma,
  input  logic [VECTOR_SIZE-1:0][J_COLS_PER_READ-1:0][J_ELEMENT_WIDTH-1:0] J_Matrix_chunk,
  input  logic [ENERGY_WIDTH-1:0]                                          Energy_previous,
  output logic                                                             busy,
  output logic [ENERGY_WIDTH-1:0]                                          energy,
  output logic                                                             done,
  output logic                                                             early_stop
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] k_q, k_d;
  energy_t acc_q, acc_d, energy_q, energy_d, Energy_next;
  logic [VECTOR_SIZE-1:0] sigma_q, sigma_d;
  logic done_q, done_d, early_stop_q, early_stop_d;
  logic start_enable, last, stop;
  dot_t dot [J_COLS_PER_READ];
  logic col_s [J_COLS_PER_READ];

  for (genvar c = 0; c < J_COLS_PER_READ; c++) begin : g_col
    logic [VECTOR_SIZE-1:0][J_ELEMENT_WIDTH-1:0] col;
    always_comb begin
      for (int r = 0; r < VECTOR_SIZE; r++) col[r] = J_Matrix_chunk[r][c];
    end
    assign col_s[c] = sigma_q[{k_q, COL_W'(c)}];
    signed_col_dot u_dot (.sigma(sigma_q), .col(col), .dot(dot[c]));
  end

  assign start_enable = state_q == RUN;

  always_comb begin
    Energy_next = acc_q;
    for (int c = 0; c < J_COLS_PER_READ; c++) begin
      Energy_next = col_s[c] ? Energy_next + energy_t'(dot[c]) : Energy_next - energy_t'(dot[c]);
    end
  end

  // all-ones Energy_previous means "no previous energy": never abort
  assign last = k_q == CNT_W'(NUM_J_CHUNKS - 1);
  assign stop = !last && (Energy_previous != '1) && (Energy_next > energy_t'(Energy_previous));

  always_comb begin
    state_d = state_q;
    k_d = k_q;
    acc_d = acc_q;
    sigma_d = sigma_q;
    energy_d = energy_q;
    done_d = 1'b0;
    early_stop_d = early_stop_q;
    if (!start_enable && start) begin
      state_d = RUN;
      k_d = '0;
      acc_d = '0;
      sigma_d = sigma;
      early_stop_d = 1'b0;
    end else if (start_enable) begin
      acc_d = Energy_next;
      k_d = k_q + 1'b1;
      if (last || stop) begin
        state_d = IDLE;
        energy_d = Energy_next;
        done_d = 1'b1;
        early_stop_d = stop;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q <= '0;
      acc_q <= '0;
      sigma_q <= '0;
      energy_q <= '0;
      done_q <= 1'b0;
      early_stop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      acc_q <= acc_d;
      sigma_q <= sigma_d;
      energy_q <= energy_d;
      done_q <= done_d;
      early_stop_q <= early_stop_d;
    end
  end

  assign busy = start_enable;
  assign energy = energy_q;
  assign done = done_q;
  assign early_stop = early_stop_q;
endmodule

// File: tb/tb_mat_mul_energy.sv
// tb_mat_mul_energy: directed and random runs checked against a direct s^T J s model
module tb_mat_mul_energy;
  localparam int N = 256;
  localparam logic [20:0] NO_PREV = 21'h1FFFFF;
  localparam int NOCHK = 32'h7FFFFFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [N-1:0] sigma = '0;
  logic [N-1:0][3:0][3:0] chunk;
  logic [20:0] Energy_previous = NO_PREV;
  logic busy, done, early_stop;
  logic [20:0] energy;

  int n_assert = 0;
  int n_fail = 0;
  int kk = 0;
  logic [3:0] jm [N][N];

  mat_mul_energy dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sigma(sigma),
    .J_Matrix_chunk(chunk), .Energy_previous(Energy_previous),
    .busy(busy), .energy(energy), .done(done), .early_stop(early_stop)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < 4; c++) chunk[r][c] = jm[r][(kk * 4 + c) % N];
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_const(input logic [3:0] v);
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) jm[r][c] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) jm[r][c] = 4'($urandom);
  endtask

  function automatic logic [N-1:0] rand_sigma();
    logic [N-1:0] s;
    for (int i = 0; i < N / 32; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  // energy accumulated column by column in memory order; abort when it exceeds the previous energy
  function automatic void model(input logic [N-1:0] s, input logic [20:0] ep,
                                output int e, output int cyc, output int es);
    int epi, d, j;
    epi = $signed(ep);
    e = 0; cyc = N / 4; es = 0;
    for (int k = 0; k < N / 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        j = k * 4 + c;
        d = 0;
        for (int r = 0; r < N; r++) d += s[r] ? int'(jm[r][j]) : -int'(jm[r][j]);
        e += s[j] ? d : -d;
      end
      if (k < N / 4 - 1 && ep != NO_PREV && e > epi) begin
        cyc = k + 1; es = 1;
        return;
      end
    end
  endfunction

  task automatic run(input string tag, input logic [N-1:0] s, input logic [20:0] ep,
                     input int want, input int bump, input int rst_at);
    int e, ecyc, es, cyc, dn;
    model(s, ep, e, ecyc, es);
    sigma = s;
    Energy_previous = ep;
    @(negedge clk);
    start = 1'b1;
    kk = 0;
    @(posedge clk);
    #1 start = 1'b0;
    sigma = ~s;
    cyc = 0;
    dn = 0;
    while (busy && cyc < 200) begin
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_busy"}, busy, 0);
        chk({tag, "_rst_energy"}, energy, 0);
        chk({tag, "_rst_done"}, done, 0);
        chk({tag, "_rst_es"}, early_stop, 0);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_post_rst_busy"}, busy, 0);
        chk({tag, "_post_rst_done"}, done, 0);
        return;
      end
      if (cyc == bump) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc++;
      kk++;
      dn += int'(done);
    end
    chk({tag, "_cycles"}, cyc, ecyc);
    chk({tag, "_energy"}, $signed(energy), e);
    if (want != NOCHK) chk({tag, "_energy_const"}, $signed(energy), want);
    chk({tag, "_early_stop"}, early_stop, es);
    chk({tag, "_done_seen"}, dn, 1);
    @(posedge clk);
    #1;
    chk({tag, "_done_drop"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [N-1:0] alt;
    alt = {(N / 2){2'b01}};
    fill_const(4'd1);
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_energy", energy, 0);
    chk("reset_done", done, 0);
    chk("reset_es", early_stop, 0);
    rst_n = 1'b1;
    run("j1_all0", '0, NO_PREV, 65536, -1, -1);
    run("j1_all1", '1, NO_PREV, 65536, -1, -1);
    run("j1_alt", alt, NO_PREV, 0, -1, -1);
    fill_const(4'd15);
    run("j15_all0", '0, NO_PREV, 983040, -1, -1);
    run("j15_all1", '1, NO_PREV, 983040, -1, -1);
    run("j15_alt", alt, NO_PREV, 0, -1, -1);
    run("early", '1, 21'd100, 15360, -1, -1);
    run("j15_all0b", '0, NO_PREV, 983040, -1, 30);
    run("after_rst", '0, NO_PREV, 983040, -1, -1);
    fill_rand();
    run("bump", rand_sigma(), NO_PREV, NOCHK, 10, -1);
    for (int i = 0; i < 3; i++) begin
      fill_rand();
      run($sformatf("rand%0d", i), rand_sigma(), NO_PREV, NOCHK, -1, -1);
    end
    for (int i = 0; i < 3; i++) begin
      fill_rand();
      run($sformatf("rand_ep%0d", i), rand_sigma(), 21'($urandom_range(0, 3000)), NOCHK, -1, -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mat_mul_energy.md
Name: mat_mul_energy

Overview:
- Iterative Ising-style energy engine: computes E = s^T·J·s over a VECTOR_SIZE×VECTOR_SIZE unsigned J matrix.
- Spin s_i = +1 when sigma[i]=1 and −1 when sigma[i]=0.
- J is streamed from memory as column chunks of J_COLS_PER_READ columns per clock, one full memory word per cycle.
- Sits between the J-matrix memory and the annealing controller, which supplies the previous energy for early termination.

Parameters:
- MEM_BANDWIDTH, 4096: bits per memory read.
- VECTOR_SIZE, 256: spin count N.
- J_ELEMENT_WIDTH, 4: unsigned J element width.
- J_COLS_PER_READ, MEM_BANDWIDTH/(VECTOR_SIZE·J_ELEMENT_WIDTH) = 4: columns per chunk (derived).
- NUM_J_CHUNKS, VECTOR_SIZE/J_COLS_PER_READ = 64: cycles per run (derived).
- INT_RESULT_WIDTH, clog2(N)+J_ELEMENT_WIDTH+1 = 13: signed column dot-product width.
- ENERGY_WIDTH, J_ELEMENT_WIDTH+2·clog2(N)+1 = 21: signed energy width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle run request.
- sigma  in  VECTOR_SIZE  spin vector; 1=+1, 0=−1.
- J_Matrix_chunk  in  [VECTOR_SIZE][J_COLS_PER_READ]×J_ELEMENT_WIDTH  current chunk; element [r][c] = J[r][k·J_COLS_PER_READ+c].
- Energy_previous  in  ENERGY_WIDTH  signed previous energy; all-ones disables early stop.
- busy  out  1  equals internal start_enable.
- energy  out  ENERGY_WIDTH  signed final energy register.
- done  out  1  one-cycle pulse at end of run.
- early_stop  out  1  run was aborted; sticky until next start.

Behaviour:
- Reset (async, rst_n=0):
  - start_enable=0, chunk counter k=0, accumulator=0.
  - energy=0, done=0, early_stop=0.
  - Reset mid-run aborts immediately. No done pulse follows.
- Start:
  - start=1 sampled at a clk edge while start_enable=0 sets start_enable=1, k=0, accumulator=0, early_stop=0.
  - sigma is latched into sigma_reg on the same edge.
  - start while busy is ignored.
- Each cycle with start_enable=1, the chunk on J_Matrix_chunk is chunk k:
  - dot_c = Σ_r s_r·J[r][c], with J zero-extended (unsigned, so J=15 means +15). Signed INT_RESULT_WIDTH; |dot| ≤ 3840.
  - Energy_next (internal combinational signal, must exist by that name) = accumulator + Σ_c s_(k·J_COLS_PER_READ+c)·dot_c. Signed ENERGY_WIDTH; |E| ≤ 983040, no overflow.
  - At the edge: accumulator ← Energy_next, k ← k+1.
- End of run:
  - At the edge where k = NUM_J_CHUNKS−1: start_enable ← 0, energy ← Energy_next, done=1 for one cycle.
  - start_enable is therefore high for exactly NUM_J_CHUNKS cycles.
  - Energy_next during the final busy cycle is the complete energy.
- Early stop:
  - Enabled only when Energy_previous ≠ all-ones.
  - Checked at any busy edge with k < NUM_J_CHUNKS−1.
  - If signed Energy_next > signed Energy_previous: start_enable ← 0, energy ← Energy_next, early_stop ← 1, done pulses.
- Constant-J identity: with C1 = popcount(sigma), E = (2·C1−N)²·J.
- Upstream must present chunk k on the cycle in which the counter equals k. The block issues no read requests.

Decomposition:
- Package mat_mul_pkg holds:
  - default parameters;
  - derived widths J_COLS_PER_READ, NUM_J_CHUNKS, INT_RESULT_WIDTH, ENERGY_WIDTH;
  - chunk-counter width clog2(NUM_J_CHUNKS);
  - signed typedefs dot_t and energy_t.
- Sub-module signed_col_dot: one column's ±J add/subtract reduction tree over VECTOR_SIZE inputs. Instantiated J_COLS_PER_READ times.
- Top: control FSM (IDLE/RUN), counter, accumulator.

Test Plan:
- sigma all 0, J≡1, Energy_previous=all-ones → busy exactly 64 cycles, energy=65536, done one pulse, early_stop=0.
- sigma all 1, J≡1 → 65536; sigma alternating (even bits 1), J≡1 → 0.
- J≡15 with sigma all 0 / all 1 / alternating → 983040 / 983040 / 0 (J treated unsigned).
- Energy_previous=100, sigma all 1, J≡15 → aborts after chunk 0 (Energy_next=15360), early_stop=1, busy high 1 cycle, energy=15360.
- rst_n low at k=30 → all outputs 0 immediately; next start gives correct full result. start pulsed while busy → no restart, result unchanged.
